// File: rtl/dec_secded_pipe_if.sv
// ---------------------------------------------------------------------------
// dec_secded_pipe_if
//   Streaming bus between a SECDED decoder and its neighbours.
//
//   Upstream side   : in_codeword / in_valid / in_ready
//   Downstream side : out_data / out_sec / out_ded / out_err_pos /
//                     out_syndrome / out_valid / out_ready
//
//   modport master : the environment (drives codewords, accepts results)
//   modport slave  : the decoder
//
//   Widths follow the codeword width: K = log2(CW_WIDTH) syndrome bits,
//   D = CW_WIDTH-K-1 data bits.
// ---------------------------------------------------------------------------
interface dec_secded_pipe_if #(
    parameter int CW_WIDTH = 16
);
    localparam int K = $clog2(CW_WIDTH);
    localparam int D = CW_WIDTH - K - 1;

    logic [CW_WIDTH-1:0] in_codeword;
    logic                in_valid;
    logic                in_ready;

    logic [D-1:0]        out_data;
    logic                out_sec;
    logic                out_ded;
    logic [K-1:0]        out_err_pos;
    logic [K:0]          out_syndrome;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_codeword, in_valid, out_ready,
        input  in_ready, out_data, out_sec, out_ded, out_err_pos,
               out_syndrome, out_valid
    );

    modport slave (
        input  in_codeword, in_valid, out_ready,
        output in_ready, out_data, out_sec, out_ded, out_err_pos,
               out_syndrome, out_valid
    );
endinterface

// File: rtl/dec_secded_pipe.sv
// ---------------------------------------------------------------------------
// dec_secded_pipe
//   Two-stage pipelined Hamming SECDED decoder with valid/ready flow control
//   and saturating single/double error counters.
//
//   Codeword layout (K = log2(CW_WIDTH)):
//     bit b, b < K   : Hamming parity, column 2^b
//     bit K          : overall parity, column 0
//     bit K+1+j      : data bit j, column = j-th integer >= 3 that is not a
//                      power of two
//
//   Ports
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     bus        : dec_secded_pipe_if.slave (codeword in, decoded result out)
//     clr_cnt    : synchronous clear of both counters (wins over increment)
//     sec_count  : saturating count of delivered single-error words
//     ded_count  : saturating count of delivered double-error words
//
//   Stage 1 registers the data field and {overall parity, syndrome};
//   stage 2 registers corrected data, flags, error position and syndrome.
//   Latency is two cycles from the input handshake to out_valid.
// ---------------------------------------------------------------------------
module dec_secded_pipe #(
    parameter int CW_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dec_secded_pipe_if.slave     bus,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] sec_count,
    output logic [CNT_WIDTH-1:0] ded_count
);

    localparam int K = $clog2(CW_WIDTH);
    localparam int D = CW_WIDTH - K - 1;

    // Position reported when the syndrome is zero but parity is odd: the
    // overall parity bit itself was flipped.
    localparam logic [K-1:0] OVERALL_POS = K[K-1:0];

    // -----------------------------------------------------------------------
    // Column assigned to codeword bit i. Parity bits carry one-hot columns,
    // the overall parity bit carries column 0 and data bits take the
    // remaining non-power-of-two values in ascending order.
    // -----------------------------------------------------------------------
    function automatic logic [K-1:0] col_of(input int i);
        int n;
        col_of = '0;
        n      = K + 1;
        if (i < K) begin
            col_of[i] = 1'b1;
        end else if (i > K) begin
            for (int c = 3; c < CW_WIDTH; c++) begin
                if ((c & (c - 1)) != 0) begin
                    if (n == i) col_of = c[K-1:0];
                    n++;
                end
            end
        end
    endfunction

    // -----------------------------------------------------------------------
    // Handshake: a stage loads when it is empty or when its content moves on.
    // -----------------------------------------------------------------------
    logic v1;
    logic v2;
    logic ld1;
    logic ld2;

    assign ld2          = !v2 || bus.out_ready;
    assign ld1          = !v1 || ld2;
    assign bus.in_ready = ld1;
    assign bus.out_valid = v2;

    // -----------------------------------------------------------------------
    // Stage 1 combinational: syndrome is the XOR of the columns of all set
    // bits; the overall parity is the XOR of every bit.
    // -----------------------------------------------------------------------
    logic [K-1:0] s1_syn;
    logic         s1_par;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        s1_syn = '0;
        for (int i = 0; i < CW_WIDTH; i++) begin
            if (bus.in_codeword[i]) s1_syn ^= col_of(i);
        end
        s1_par = ^bus.in_codeword;
    end

    // Only the data field is carried forward: the parity bits are fully
    // summarised by {s1_par, s1_syn}, and a flipped parity bit needs no
    // correction in the delivered data.
    logic [D-1:0] d1;
    logic [K-1:0] syn1;
    logic         par1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            v1 <= 1'b0;
        end else if (ld1) begin
            v1 <= bus.in_valid;
        end
    end

    // NOTE: stage-1 payload has no reset; v1 qualifies it, so its contents
    // after reset are never observed.
    always_ff @(posedge clk) begin
        if (ld1 && bus.in_valid) begin
            d1   <= bus.in_codeword[CW_WIDTH-1:K+1];
            syn1 <= s1_syn;
            par1 <= s1_par;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 combinational: classify, locate and correct.
    //   par=1           -> single error at the bit whose column equals syn
    //   par=0, syn!=0   -> double error, data passed through
    //   par=0, syn=0    -> clean
    // -----------------------------------------------------------------------
    logic [K-1:0] s2_pos;
    logic         s2_sec;
    logic         s2_ded;
    logic [D-1:0] s2_data;
    logic [K-1:0] s2_err_pos;

    always_comb begin
        s2_pos = OVERALL_POS;
        for (int i = 0; i < CW_WIDTH; i++) begin
            if (i != K && col_of(i) == syn1) s2_pos = i[K-1:0];
        end

        s2_sec = par1;
        s2_ded = !par1 && (syn1 != '0);

        // A data bit is inverted only when it is the located single error.
        for (int j = 0; j < D; j++) begin
            s2_data[j] = d1[j] ^ (par1 && (col_of(K + 1 + j) == syn1));
        end

        s2_err_pos = s2_sec ? s2_pos : '0;
    end

    // -----------------------------------------------------------------------
    // Stage 2 registers. Fields change only when a valid word moves in, so
    // they hold stable while the consumer stalls and ignore bubbles.
    // -----------------------------------------------------------------------
    logic [D-1:0] out_data_r;
    logic         out_sec_r;
    logic         out_ded_r;
    logic [K-1:0] out_err_pos_r;
    logic [K:0]   out_syndrome_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2             <= 1'b0;
            out_data_r     <= '0;
            out_sec_r      <= 1'b0;
            out_ded_r      <= 1'b0;
            out_err_pos_r  <= '0;
            out_syndrome_r <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                out_data_r     <= s2_data;
                out_sec_r      <= s2_sec;
                out_ded_r      <= s2_ded;
                out_err_pos_r  <= s2_err_pos;
                out_syndrome_r <= {par1, syn1};
            end
        end
    end

    assign bus.out_data     = out_data_r;
    assign bus.out_sec      = out_sec_r;
    assign bus.out_ded      = out_ded_r;
    assign bus.out_err_pos  = out_err_pos_r;
    assign bus.out_syndrome = out_syndrome_r;

    // -----------------------------------------------------------------------
    // Error counters: count delivered words only, saturate at all-ones;
    // clear has priority over a coincident increment.
    // -----------------------------------------------------------------------
    logic out_hs;
    assign out_hs = v2 && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (clr_cnt) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (out_hs) begin
            if (out_sec_r && sec_count != '1) sec_count <= sec_count + CNT_WIDTH'(1);
            if (out_ded_r && ded_count != '1) ded_count <= ded_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dec_secded_pipe.sv
// ---------------------------------------------------------------------------
// tb_dec_secded_pipe
//   Scoreboard bench for dec_secded_pipe (CW_WIDTH=16). Stimulus pushes the
//   reference model's expected result into a queue at each input handshake;
//   a monitor compares every presented output with the queue head and pops
//   on the output handshake. A second instance with CNT_WIDTH=2 shares the
//   stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_dec_secded_pipe;

    localparam int CW = 16;

    logic        clk;
    logic        rst_n;
    logic        clr_cnt;
    logic [15:0] sec_count;
    logic [15:0] ded_count;
    logic [1:0]  sec_count2;
    logic [1:0]  ded_count2;

    dec_secded_pipe_if #(.CW_WIDTH(CW)) bus ();
    dec_secded_pipe_if #(.CW_WIDTH(CW)) bus2 ();

    assign bus2.in_codeword = bus.in_codeword;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.out_ready   = bus.out_ready;

    dec_secded_pipe #(.CW_WIDTH(CW), .CNT_WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_cnt   (clr_cnt),
        .sec_count (sec_count),
        .ded_count (ded_count)
    );

    dec_secded_pipe #(.CW_WIDTH(CW), .CNT_WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2),
        .clr_cnt   (clr_cnt),
        .sec_count (sec_count2),
        .ded_count (ded_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Column of each codeword bit, written out from the layout rule.
    int col_tab [16] = '{1, 2, 4, 8, 0, 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct {
        logic [10:0] data;
        logic        sec;
        logic        ded;
        logic [3:0]  pos;
        logic [4:0]  syn;
    } exp_t;

    exp_t exp_q [$];

    function automatic exp_t model(input logic [15:0] cw);
        exp_t        e;
        int          s;
        logic        p;
        logic [15:0] f;
        s = 0;
        for (int i = 0; i < 16; i++) if (cw[i]) s = s ^ col_tab[i];
        p     = ^cw;
        f     = cw;
        e.sec = p;
        e.ded = !p && (s != 0);
        e.pos = 4'd0;
        if (p) begin
            for (int i = 0; i < 16; i++) begin
                if (col_tab[i] == s) begin
                    e.pos = i[3:0];
                    f[i]  = ~f[i];
                end
            end
        end
        e.data = f[15:5];
        e.syn  = {p, s[3:0]};
        return e;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        int          s;
        cw = {d, 5'b0};
        s  = 0;
        for (int i = 5; i < 16; i++) if (cw[i]) s = s ^ col_tab[i];
        cw[3:0] = s[3:0];
        cw[4]   = ^cw;
        return cw;
    endfunction

    // Valid codeword with 0, 1 or 2 distinct flipped bits, occasionally raw noise.
    function automatic logic [15:0] gen_word();
        logic [15:0] cw;
        int          nerr;
        int          a;
        int          b;
        cw   = encode(11'($urandom));
        nerr = $urandom_range(0, 2);
        a    = $urandom_range(0, 15);
        if (nerr >= 1) cw[a] = ~cw[a];
        if (nerr == 2) begin
            b     = (a + $urandom_range(1, 15)) % 16;
            cw[b] = ~cw[b];
        end
        if ($urandom_range(0, 9) == 0) cw = 16'($urandom);
        return cw;
    endfunction

    function automatic logic [15:0] gen_single();
        logic [15:0] cw;
        int          a;
        cw    = encode(11'($urandom));
        a     = $urandom_range(0, 15);
        cw[a] = ~cw[a];
        return cw;
    endfunction

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    int m_sec;
    int m_ded;
    int m_sec2;
    int m_ded2;

    // Monitor: compares presented outputs with the queue head every cycle
    // (so stalled fields must keep matching), pops on handshake, and tracks
    // the expected counter values.
    always @(negedge clk) begin
        exp_t e;
        bit   hs_sec;
        bit   hs_ded;
        if (!rst_n) begin
            exp_q.delete();
            m_sec  = 0;
            m_ded  = 0;
            m_sec2 = 0;
            m_ded2 = 0;
        end else begin
            hs_sec = 0;
            hs_ded = 0;
            check("sec_count",  sec_count,  m_sec);
            check("ded_count",  ded_count,  m_ded);
            check("sec_count2", sec_count2, m_sec2);
            check("ded_count2", ded_count2, m_ded2);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", bus.out_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("out_data",     bus.out_data,     e.data);
                    check("out_sec",      bus.out_sec,      e.sec);
                    check("out_ded",      bus.out_ded,      e.ded);
                    check("out_err_pos",  bus.out_err_pos,  e.pos);
                    check("out_syndrome", bus.out_syndrome, e.syn);
                    if (bus.out_ready) begin
                        e      = exp_q.pop_front();
                        hs_sec = e.sec;
                        hs_ded = e.ded;
                    end
                end
            end
            if (clr_cnt) begin
                m_sec  = 0;
                m_ded  = 0;
                m_sec2 = 0;
                m_ded2 = 0;
            end else begin
                if (hs_sec && m_sec  < 65535) m_sec++;
                if (hs_ded && m_ded  < 65535) m_ded++;
                if (hs_sec && m_sec2 < 3)     m_sec2++;
                if (hs_ded && m_ded2 < 3)     m_ded2++;
            end
        end
    end

    // ---------------- downstream backpressure ----------------
    int bp_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] cw);
        bit ok;
        ok              = 0;
        bus.in_codeword = cw;
        bus.in_valid    = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) exp_q.push_back(model(cw));
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] w [4];
        int          idx;

        rst_n           = 1'b0;
        clr_cnt         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_codeword = 16'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready,     1);
        check("rst_out_valid", bus.out_valid,    0);
        check("rst_out_data",  bus.out_data,     0);
        check("rst_syndrome",  bus.out_syndrome, 0);
        check("rst_sec_count", sec_count,        0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean all-zero word and two-cycle latency
        send(16'h0000);
        check("latency_cycle1_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_cycle2_valid", bus.out_valid, 1);
        drain();

        // Directed error patterns
        send(16'h0100);
        send(16'h0010);
        send(16'h0060);
        drain();
        check("dir_sec_count", sec_count, 2);
        check("dir_ded_count", ded_count, 1);

        // Stall: only two words fit while downstream is blocked
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) w[i] = gen_word();
        idx          = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_codeword = w[idx];
            @(negedge clk);
            if (bus.in_ready && idx < 4) begin
                exp_q.push_back(model(w[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        check("stall_accepted_words", idx, 2);
        check("stall_in_ready",       bus.in_ready, 0);
        bp_mode = 0;
        for (int i = idx; i < 4; i++) send(w[i]);
        drain();

        // Random traffic under random backpressure, with idle gaps
        bp_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid    = 1'b0;
                bus.in_codeword = 16'($urandom);
                @(posedge clk);
                #1;
            end
            send(gen_word());
        end

        // Reset with words in flight
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid,    0);
        check("midrst_in_ready",  bus.in_ready,     1);
        check("midrst_out_data",  bus.out_data,     0);
        check("midrst_out_sec",   bus.out_sec,      0);
        check("midrst_out_ded",   bus.out_ded,      0);
        check("midrst_err_pos",   bus.out_err_pos,  0);
        check("midrst_syndrome",  bus.out_syndrome, 0);
        check("midrst_sec_count", sec_count,        0);
        check("midrst_ded_count", ded_count,        0);
        bp_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("postrst_no_leftover", bus.out_valid, 0);
        send(gen_word());
        check("postrst_latency_cycle1", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("postrst_latency_cycle2", bus.out_valid, 1);
        drain();

        // Saturation of the 2-bit counters, then clear on the fifth handshake
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 4; i++) send(gen_single());
        drain();
        check("sat_sec_count2", sec_count2, 3);
        check("sat_sec_count",  sec_count,  4);
        send(gen_single());
        @(posedge clk);
        #1;
        check("fifth_out_valid", bus.out_valid, 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_sec_count2", sec_count2, 0);
        check("clr_sec_count",  sec_count,  0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/dec_secded_pipe.md
DEC_SECDED_PIPE -- requirements
Module: dec_secded_pipe

Interface
REQ-001 Parameter: CW_WIDTH, default 16, codeword width; legal values 8, 16, 32; derived K = log2(CW_WIDTH), D = CW_WIDTH-K-1 (4/11/26).
REQ-002 Parameter: CNT_WIDTH, default 16, width of each error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_codeword  input  CW_WIDTH  received codeword, possibly corrupted.
REQ-006 in_valid  input  1  in_codeword valid.
REQ-007 in_ready  output  1  block accepts in_codeword this cycle.
REQ-008 out_data  output  D  corrected data word.
REQ-009 out_sec  output  1  single error detected and corrected.
REQ-010 out_ded  output  1  double error detected; uncorrectable.
REQ-011 out_err_pos  output  K  flipped codeword bit index; meaningful only when out_sec=1, else 0.
REQ-012 out_syndrome  output  K+1  {overall parity, K-bit syndrome} of the word.
REQ-013 out_valid  output  1  output fields valid.
REQ-014 out_ready  input  1  downstream accepts the output.
REQ-015 clr_cnt  input  1  synchronous clear of both counters.
REQ-016 sec_count, ded_count  output  CNT_WIDTH each  saturating counts of delivered SEC/DED words.

Function
REQ-017 Codeword layout: bit b (b<K) is Hamming parity for syndrome bit b (column 2^b); bit K is overall parity; bit K+1+j is data bit j, carrying the j-th ascending integer >=3 that is not a power of two as its column (CW=16: bits 5..15 -> 3,5,6,7,9,10,11,12,13,14,15).
REQ-018 Syndrome bit b = XOR of codeword[b] and every data bit whose column has bit b set; overall parity p = XOR of all CW_WIDTH bits.
REQ-019 Classification: s=0,p=0 -> clean; p=1 -> single error; s!=0,p=0 -> double error.
REQ-020 Single-error position: s=0 -> K; s=2^b -> b; otherwise the data bit whose column equals s; the flipped bit is inverted before data extraction.
REQ-021 out_data[j] = (corrected) codeword[K+1+j]; on double error data is passed uncorrected.
REQ-022 Pipeline: stage 1 registers codeword and {p,s}; stage 2 registers corrected data, flags, position and syndrome; latency exactly 2 cycles from input handshake to out_valid with no backpressure.
REQ-023 Handshake: transfer on valid&ready at each side; stage 2 loads when !v2 | out_ready; stage 1 loads when !v1 | stage-2 load; in_ready equals the stage-1 load enable.
REQ-024 Throughput one word per cycle while out_ready=1; no word dropped, duplicated or reordered under any backpressure pattern.
REQ-025 While out_valid=1 and out_ready=0, all output fields hold stable.
REQ-026 sec_count/ded_count increment by 1 on each output handshake with out_sec/out_ded set, saturating at 2^CNT_WIDTH-1.
REQ-027 clr_cnt=1 zeroes both counters at the next edge; clear wins over a simultaneous increment.
REQ-028 in_valid=0 words never affect counters or outputs.

Reset
REQ-029 rst_n=0 immediately clears both stage valids, out_data, out_sec, out_ded, out_err_pos, out_syndrome and both counters to 0; in_ready=1 during and after reset.
REQ-030 Reset mid-operation discards all in-flight words; first out_valid after deassertion occurs 2 cycles after the first post-reset input handshake.

Verification (CW_WIDTH=16)
REQ-031 in_codeword=16'h0000, out_ready=1 -> 2 cycles later out_data=0, out_sec=0, out_ded=0, out_syndrome=0.
REQ-032 16'h0100 (bit 8 flipped) -> out_syndrome=5'b10111, out_sec=1, out_err_pos=8, out_data=0, sec_count=1.
REQ-033 16'h0010 (bit 4 flipped) -> out_syndrome=5'b10000, out_sec=1, out_err_pos=4, out_data=0.
REQ-034 16'h0060 (bits 5,6 flipped) -> out_syndrome=5'b00110, out_ded=1, out_sec=0, out_data=11'h003, ded_count=1.
REQ-035 out_ready=0, four back-to-back inputs -> in_ready falls after two accepted words, out fields stable; out_ready=1 -> words emerge in order, none lost.
REQ-036 CNT_WIDTH=2, five single-error words then clr_cnt asserted on the fifth handshake -> sec_count saturates at 3, then reads 0.
